// File: rtl/ysyx_220066_mem_pkg.sv
// ============================================================================
// Module      : ysyx_220066_mem_pkg
// Description : MemOp encodings and store mask/alignment/data helpers shared
//               by the dmem read and write paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_220066_mem_pkg;

    typedef enum logic [2:0] {
        MEMOP_SB  = 3'b000,
        MEMOP_SH  = 3'b001,
        MEMOP_SW  = 3'b010,
        MEMOP_SD  = 3'b011,
        MEMOP_LBU = 3'b100,
        MEMOP_LHU = 3'b101,
        MEMOP_LWU = 3'b110
    } memop_e;

    localparam int unsigned c_LINE_OFF_W = 3;

    function automatic logic [7:0] byte_mask(input logic [2:0] op, input logic [2:0] off);
        logic [7:0] base;
        case (op)
            MEMOP_SB: base = 8'h01;
            MEMOP_SH: base = 8'h03;
            MEMOP_SW: base = 8'h0F;
            MEMOP_SD: base = 8'hFF;
            default:  base = 8'h00;
        endcase
        return base << off;
    endfunction

    // Load codes are not legal store sizes, so they fail the check as well.
    function automatic logic is_aligned(input logic [2:0] op, input logic [2:0] off);
        logic ok;
        case (op)
            MEMOP_SB: ok = 1'b1;
            MEMOP_SH: ok = (off[0] == 1'b0);
            MEMOP_SW: ok = (off[1:0] == 2'b00);
            MEMOP_SD: ok = (off == 3'b000);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [63:0] store_data(input logic [2:0] op, input logic [2:0] off,
                                               input logic [63:0] data);
        logic [63:0] t;
        case (op)
            MEMOP_SB: t = {56'd0, data[7:0]};
            MEMOP_SH: t = {48'd0, data[15:0]};
            MEMOP_SW: t = {32'd0, data[31:0]};
            default:  t = data;
        endcase
        return t << {off, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_220066_wr_fifo.sv
// ============================================================================
// Module      : ysyx_220066_wr_fifo
// Description : In-order store queue of {addr, wdata, wmask} with per-entry
//               valid bits and addresses exposed for load-conflict compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_220066_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [AW-1:0]                push_addr_i,
    input  logic [63:0]                  push_wdata_i,
    input  logic [7:0]                   push_wmask_i,
    input  logic                         pop_i,
    output logic [AW-1:0]                head_addr_o,
    output logic [63:0]                  head_wdata_o,
    output logic [7:0]                   head_wmask_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][AW-1:0]     ent_addr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    addr_q  [DEPTH];
    logic [63:0]      wdata_q [DEPTH];
    logic [7:0]       wmask_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        valid_d = valid_q;
        if (do_pop) begin
            rptr_d          = rptr_q + PW'(1);
            valid_d[rptr_q] = 1'b0;
        end
        if (do_push) begin
            wptr_d          = wptr_q + PW'(1);
            valid_d[wptr_q] = 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset; valid_q qualifies every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wptr_q]  <= push_addr_i;
            wdata_q[wptr_q] <= push_wdata_i;
            wmask_q[wptr_q] <= push_wmask_i;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign ent_addr_o[i] = addr_q[i];
        end
    endgenerate

    assign head_addr_o  = addr_q[rptr_q];
    assign head_wdata_o = wdata_q[rptr_q];
    assign head_wmask_o = wmask_q[rptr_q];
    assign count_o      = count_q;
    assign valid_o      = valid_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_220066_dmem_wr.sv
// ============================================================================
// Module      : ysyx_220066_dmem_wr
// Description : Store unit: legality check, line/mask/data encoding, store
//               queue drain over req/ack, and load-line conflict detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_220066_dmem_wr
    import ysyx_220066_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemWr,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   data,
    input  logic [2:0]    MemOp,
    output logic          wr_ready,
    output logic          error,
    output logic          bus_err,
    output logic          busy,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_conflict,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_ack,
    input  logic          mem_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [c_LINE_OFF_W-1:0] off;
    logic                    take;
    logic                    legal;
    logic                    push;
    logic                    pop;
    logic [AW-1:0]           line_addr;
    logic [63:0]             enc_wdata;
    logic [7:0]              enc_wmask;
    logic [CW-1:0]           count;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic                    ld_hit;
    logic                    error_q, error_d;
    logic                    bus_err_q, bus_err_d;
    logic                    ld_addr_unused;

    assign off       = addr[c_LINE_OFF_W-1:0];
    assign legal     = is_aligned(MemOp, off);
    assign take      = MemWr && wr_ready;
    assign push      = take && legal;
    assign pop       = mem_req && mem_ack;
    assign line_addr = {addr[AW-1:3], 3'b000};
    assign enc_wmask = byte_mask(MemOp, off);
    assign enc_wdata = store_data(MemOp, off, data);

    ysyx_220066_wr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_addr_i  (line_addr),
        .push_wdata_i (enc_wdata),
        .push_wmask_i (enc_wmask),
        .pop_i        (pop),
        .head_addr_o  (mem_addr),
        .head_wdata_o (mem_wdata),
        .head_wmask_o (mem_wmask),
        .count_o      (count),
        .valid_o      (ent_valid),
        .ent_addr_o   (ent_addr)
    );

    // Acceptance looks at the registered count only: a same-cycle pop does
    // not open a slot until the following cycle.
    assign wr_ready = (count != CW'(DEPTH));
    assign mem_req  = (count != '0);
    assign busy     = mem_req;

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == {ld_addr[AW-1:3], 3'b000})) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign ld_conflict    = ld_hit;
    assign ld_addr_unused = ^ld_addr[2:0];

    always_comb begin
        error_d   = take && !legal;
        bus_err_d = bus_err_q | (pop && mem_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            error_q   <= error_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign error   = error_q;
    assign bus_err = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_220066_dmem_wr.sv
// ============================================================================
// Module      : tb_ysyx_220066_dmem_wr
// Description : Scoreboard bench for the store unit with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_220066_dmem_wr;

    localparam int DEPTH = 2;
    localparam int AW    = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          MemWr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [63:0]   data = '0;
    logic [2:0]    MemOp = '0;
    logic [AW-1:0] ld_addr = '0;
    logic          mem_ack = 1'b0;
    logic          mem_err = 1'b0;
    logic          wr_ready, error, bus_err, busy, ld_conflict, mem_req;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wmask;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
    } wr_t;

    wr_t exp_q[$];
    bit  exp_err = 1'b0;
    bit  mdl_be  = 1'b0;
    bit  mon_en  = 1'b0;
    bit  mon_hit;
    int  n_vec = 0;
    int  n_bad = 0;

    ysyx_220066_dmem_wr #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .MemWr(MemWr), .addr(addr), .data(data), .MemOp(MemOp),
        .wr_ready(wr_ready), .error(error), .bus_err(bus_err), .busy(busy),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] op);
        return 1 << op;
    endfunction

    function automatic bit legal_m(input logic [2:0] op, input logic [63:0] a);
        if (op > 3'd3) return 1'b0;
        return (a % nbytes(op)) == 0;
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % 8);
    endfunction

    function automatic wr_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
        wr_t         w;
        int          nb;
        int          sh;
        logic [63:0] keep;
        nb   = nbytes(op);
        sh   = int'(a % 8);
        keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        w.a  = a;
        w.d  = (d & keep) << (8 * sh);
        w.m  = 8'((((1 << nb) - 1) << sh) & 255);
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive_cycle(input bit wr, input logic [2:0] op, input logic [63:0] a,
                               input logic [63:0] d, input bit ack, input bit err,
                               input logic [63:0] lda, output bit took);
        @(negedge clk);
        MemWr = wr; MemOp = op; addr = a; data = d;
        mem_ack = ack; mem_err = err; ld_addr = lda;
        #3;
        took = wr && wr_ready;
        @(posedge clk);
        #1;
        exp_err = took && !legal_m(op, a);
        if (took && legal_m(op, a)) exp_q.push_back(model(op, a, d));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        #4;
        if (mon_en) begin
            chk("mem_req", mem_req, exp_q.size() != 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("wr_ready", wr_ready, exp_q.size() < DEPTH);
            chk("error", error, exp_err);
            chk("bus_err", bus_err, mdl_be);
            mon_hit = 1'b0;
            foreach (exp_q[i]) if (line_of(exp_q[i].a) == line_of(ld_addr)) mon_hit = 1'b1;
            chk("ld_conflict", ld_conflict, mon_hit);
            if (exp_q.size() != 0) begin
                chk("head_addr", mem_addr, line_of(exp_q[0].a));
                chk("head_wdata", mem_wdata, exp_q[0].d);
                chk("head_wmask", mem_wmask, exp_q[0].m);
                if (mem_ack) begin
                    if (mem_err) mdl_be = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          took;
        logic [2:0]  op;
        logic [63:0] a, d, lda;

        #1 rst = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_ld_conflict", ld_conflict, 0);
        chk("rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // sb at offset 3, held for three cycles, then acked
        drive_cycle(1, 3'b000, 64'h8000_0003, 64'hFFAB, 0, 0, 0, took);
        chk("sb_took", took, 1);
        chk("sb_req", mem_req, 1);
        chk("sb_addr", mem_addr, 64'h8000_0000);
        chk("sb_mask", mem_wmask, 8'h08);
        chk("sb_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
        repeat (3) drive_cycle(0, 3'b000, 0, 0, 0, 0, 0, took);
        chk("sb_hold_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
        drive_cycle(0, 3'b000, 0, 0, 1, 0, 0, took);
        chk("sb_drained", mem_req, 0);

        // misaligned sw and illegal op, then back-to-back bad stores
        drive_cycle(1, 3'b010, 64'h8000_0006, 64'h1, 0, 0, 0, took);
        chk("misal_error", error, 1);
        chk("misal_req", mem_req, 0);
        chk("misal_busy", busy, 0);
        drive_cycle(0, 3'b000, 0, 0, 0, 0, 0, took);
        chk("misal_pulse_end", error, 0);
        drive_cycle(1, 3'b111, 64'h8000_0000, 64'h1, 0, 0, 0, took);
        chk("illop_error", error, 1);
        chk("illop_req", mem_req, 0);
        drive_cycle(1, 3'b001, 64'h8000_0001, 64'h1, 0, 0, 0, took);
        chk("b2b_error", error, 1);
        drive_cycle(0, 3'b000, 0, 0, 0, 0, 0, took);
        chk("b2b_end", error, 0);

        // three sd with no ack: third held until one slot frees
        drive_cycle(1, 3'b011, 64'h8000_0010, 64'd1, 0, 0, 0, took);
        chk("sd1_took", took, 1);
        drive_cycle(1, 3'b011, 64'h8000_0018, 64'd2, 0, 0, 0, took);
        chk("sd2_took", took, 1);
        drive_cycle(1, 3'b011, 64'h8000_0020, 64'd3, 0, 0, 0, took);
        chk("sd3_held", took, 0);
        chk("full_wr_ready", wr_ready, 0);
        drive_cycle(1, 3'b011, 64'h8000_0020, 64'd3, 1, 0, 0, took);
        chk("sd3_no_bypass", took, 0);
        drive_cycle(1, 3'b011, 64'h8000_0020, 64'd3, 0, 0, 0, took);
        chk("sd3_took", took, 1);
        chk("sd_head2", mem_wdata, 64'd2);
        repeat (3) drive_cycle(0, 3'b000, 0, 0, 1, 0, 0, took);
        chk("sd_drained", busy, 0);

        // load-line conflict
        drive_cycle(1, 3'b001, 64'h8000_1002, 64'h1234, 0, 0, 0, took);
        drive_cycle(0, 3'b000, 0, 0, 0, 0, 64'h8000_1006, took);
        chk("ldc_same_line", ld_conflict, 1);
        drive_cycle(0, 3'b000, 0, 0, 0, 0, 64'h8000_1008, took);
        chk("ldc_next_line", ld_conflict, 0);
        drive_cycle(0, 3'b000, 0, 0, 1, 0, 64'h8000_1006, took);
        chk("ldc_after_drain", ld_conflict, 0);

        // continuous ack with a store every cycle
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 3));
            a  = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 63))};
            a  = a - (a % nbytes(op));
            drive_cycle(1, op, a, {$urandom, $urandom}, 1, 0, 0, took);
            chk("stream_took", took, 1);
            chk("stream_wr_ready", wr_ready, 1);
        end
        drive_cycle(0, 3'b000, 0, 0, 1, 0, 0, took);

        // sticky bus error, then asynchronous reset with two pending
        drive_cycle(1, 3'b010, 64'h8000_2004, 64'hDEAD_BEEF, 0, 0, 0, took);
        drive_cycle(0, 3'b000, 0, 0, 1, 1, 0, took);
        chk("bus_err_set", bus_err, 1);
        drive_cycle(1, 3'b000, 64'h8000_2001, 64'h55, 1, 0, 0, took);
        drive_cycle(0, 3'b000, 0, 0, 1, 0, 0, took);
        chk("bus_err_sticky", bus_err, 1);
        drive_cycle(1, 3'b011, 64'h8000_3000, 64'hA, 0, 0, 0, took);
        drive_cycle(1, 3'b011, 64'h8000_3008, 64'hB, 0, 0, 0, took);
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        MemWr = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bus_err", bus_err, 0);
        exp_q.delete();
        mdl_be  = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        drive_cycle(0, 3'b000, 0, 0, 0, 0, 0, took);
        chk("post_rst_empty", mem_req, 0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            a  = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 63))};
            if (op <= 3'd3 && $urandom_range(0, 3) != 0) a = a - (a % nbytes(op));
            d   = {$urandom, $urandom};
            lda = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 63))};
            drive_cycle($urandom_range(0, 9) < 7, op, a, d, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15) == 0, lda, took);
        end

        repeat (4) drive_cycle(0, 3'b000, 0, 0, 1, 0, 0, took);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
